// File: rtl/mod_vec_add_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : poly_arith_pkg
//  Purpose  : Shared constants and types for polynomial coefficient
//             arithmetic. Defaults target ML-KEM (Q = 3329, 12-bit coeffs).
//  Contents : Q, W          - default modulus and coefficient width
//             coeff_t       - coefficient type for the default width
//             mode_e        - per-lane operation select
//  Revision : 1.0 - initial release
// ============================================================================
package poly_arith_pkg;

    localparam int Q = 3329;
    localparam int W = 12;

    typedef logic [W-1:0] coeff_t;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_NEG  = 2'b10,
        MODE_HALF = 2'b11
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/mod_vec_add_sub_if.sv
`default_nettype none
// ============================================================================
//  Module   : mod_vec_add_sub_if
//  Purpose  : Input/output valid-ready bus of the modular vector add/sub unit.
//  Signals  : in_valid_i/in_ready_o   - input beat handshake
//             op1_i, op2_i            - operands, lane k at [k*W +: W]
//             mode_i                  - per-lane op, lane k at [2k +: 2]
//             tag_i / tag_o           - sideband tag in / out
//             out_valid_o/out_ready_i - output beat handshake
//             result_o, range_err_o   - per-lane result and range flag
//  Modports : master - beat producer / result consumer
//             slave  - the arithmetic unit
//  Revision : 1.0 - initial release
// ============================================================================
interface mod_vec_add_sub_if #(
    parameter int W     = 12,
    parameter int LANES = 4,
    parameter int TAG_W = 4
) ();
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [LANES*W-1:0]   op1_i;
    logic [LANES*W-1:0]   op2_i;
    logic [LANES*2-1:0]   mode_i;
    logic [TAG_W-1:0]     tag_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [LANES*W-1:0]   result_o;
    logic [TAG_W-1:0]     tag_o;
    logic [LANES-1:0]     range_err_o;

    modport master (
        output in_valid_i, op1_i, op2_i, mode_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, tag_o, range_err_o
    );

    modport slave (
        input  in_valid_i, op1_i, op2_i, mode_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, tag_o, range_err_o
    );
endinterface
`default_nettype wire

// File: rtl/mod_vec_add_sub_lane.sv
`default_nettype none
// ============================================================================
//  Module   : mod_lane_core
//  Purpose  : One lane of the modular add/sub pipeline. Stage 1 prepares the
//             operands (B' = Q-B for SUB/NEG, A = 0 for NEG, range check);
//             stage 2 adds, reduces once and optionally halves mod Q.
//  Ports    : clk, rst (async, active-low)
//             en1 / en2   - load enables for stage 1 / stage 2 registers
//             op1, op2    - raw operands, mode - lane operation
//             result      - registered stage-2 result
//             range_err   - registered range flag for the same beat
//  Revision : 1.0 - initial release
// ============================================================================
module mod_lane_core #(
    parameter int Q = poly_arith_pkg::Q,
    parameter int W = poly_arith_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en1,
    input  logic         en2,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic [1:0]   mode,
    output logic [W-1:0] result,
    output logic         range_err
);
    import poly_arith_pkg::*;

    localparam logic [W:0] C_Q = Q[W:0];

    // ---------------- stage 1: operand preparation ----------------
    mode_e        w_mode;
    logic         w_err;
    logic [W-1:0] w_a_prep;
    logic [W:0]   w_b_prep;

    always_comb begin
        w_mode   = mode_e'(mode);
        w_err    = ({1'b0, op1} >= C_Q) || ({1'b0, op2} >= C_Q);
        w_a_prep = (w_mode == MODE_NEG) ? '0 : op1;
        // B' reaches Q when B = 0, hence the extra bit.
        if ((w_mode == MODE_SUB) || (w_mode == MODE_NEG)) begin
            w_b_prep = C_Q - {1'b0, op2};
        end else begin
            w_b_prep = {1'b0, op2};
        end
    end

    logic [W-1:0] r_a;
    logic [W:0]   r_b;
    logic         r_half;
    logic         r_err1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_half <= 1'b0;
            r_err1 <= 1'b0;
        end else if (en1) begin
            r_a    <= w_a_prep;
            r_b    <= w_b_prep;
            r_half <= (w_mode == MODE_HALF);
            r_err1 <= w_err;
        end
    end

    // ---------------- stage 2: reduce and halve ----------------
    logic [W:0]   w_sum;
    logic [W:0]   w_red;
    logic [W:0]   w_half_sum;
    logic [W-1:0] w_res;

    always_comb begin
        // Sum of in-range operands is at most 2Q-1, so one subtraction reduces.
        w_sum = {1'b0, r_a} + r_b;
        w_red = (w_sum >= C_Q) ? (w_sum - C_Q) : w_sum;
        // Multiplying by 2^-1 mod Q: make the value even by adding Q when odd,
        // then shift. The sum stays below 2Q so it fits in W+1 bits.
        w_half_sum = w_red + (w_red[0] ? C_Q : '0);
        if (r_half) begin
            w_res = W'(w_half_sum >> 1);
        end else begin
            w_res = W'(w_red);
        end
        if (r_err1) begin
            w_res = '0;
        end
    end

    logic [W-1:0] r_result;
    logic         r_err2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
            r_err2   <= 1'b0;
        end else if (en2) begin
            r_result <= w_res;
            r_err2   <= r_err1;
        end
    end

    assign result    = r_result;
    assign range_err = r_err2;

endmodule
`default_nettype wire

// File: rtl/mod_vec_add_sub.sv
`default_nettype none
// ============================================================================
//  Module   : mod_vec_add_sub
//  Purpose  : Multi-lane modular adder/subtractor (ADD, SUB, NEG, HALF) with a
//             two-stage elastic valid/ready pipeline and a sideband tag.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous reset, active-low
//             bus  - mod_vec_add_sub_if.slave (operands, modes, tag,
//                    results, range flags and both handshakes)
//  Revision : 1.0 - initial release
// ============================================================================
module mod_vec_add_sub #(
    parameter int Q     = poly_arith_pkg::Q,
    parameter int W     = poly_arith_pkg::W,
    parameter int LANES = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    mod_vec_add_sub_if.slave       bus
);
    import poly_arith_pkg::*;

    // ---------------- elaboration-time parameter checks ----------------
    if ((Q % 2) == 0) begin : g_chk_q_odd
        $error("mod_vec_add_sub: Q must be odd");
    end
    if ((Q <= 2) || (Q >= (1 << W))) begin : g_chk_q_range
        $error("mod_vec_add_sub: Q must satisfy 2 < Q < 2**W");
    end
    if ((LANES < 1) || (LANES > 16)) begin : g_chk_lanes
        $error("mod_vec_add_sub: LANES must be in 1..16");
    end
    if (TAG_W < 1) begin : g_chk_tag
        $error("mod_vec_add_sub: TAG_W must be at least 1");
    end

    // ---------------- valid/ready chain ----------------
    logic             r_s1_valid;
    logic             r_s2_valid;
    logic [TAG_W-1:0] r_s1_tag;
    logic [TAG_W-1:0] r_s2_tag;
    logic             w_adv1;
    logic             w_adv2;
    logic             w_load1;
    logic             w_load2;

    // Ready depends only on pipeline occupancy and downstream ready, never on
    // in_valid_i, so no combinational loop forms through an upstream source.
    assign w_adv2  = !r_s2_valid || bus.out_ready_i;
    assign w_adv1  = !r_s1_valid || w_adv2;
    // Data registers load only when a real beat moves in, so stalled or idle
    // stages keep their contents.
    assign w_load1 = w_adv1 && bus.in_valid_i;
    assign w_load2 = w_adv2 && r_s1_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s2_tag   <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= bus.in_valid_i;
            end
            if (w_load1) begin
                r_s1_tag <= bus.tag_i;
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_load2) begin
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    // ---------------- lanes ----------------
    logic [LANES*W-1:0] w_result;
    logic [LANES-1:0]   w_range_err;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mod_lane_core #(
            .Q (Q),
            .W (W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en1       (w_load1),
            .en2       (w_load2),
            .op1       (bus.op1_i[k*W +: W]),
            .op2       (bus.op2_i[k*W +: W]),
            .mode      (bus.mode_i[k*2 +: 2]),
            .result    (w_result[k*W +: W]),
            .range_err (w_range_err[k])
        );
    end

    assign bus.in_ready_o  = w_adv1;
    assign bus.out_valid_o = r_s2_valid;
    assign bus.tag_o       = r_s2_tag;
    assign bus.result_o    = w_result;
    assign bus.range_err_o = w_range_err;

endmodule
`default_nettype wire

// File: tb/tb_mod_vec_add_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_vec_add_sub
//  Purpose  : Self-checking bench for mod_vec_add_sub (LANES=4, Q=3329).
//             Expected values come from an arithmetic reference model of the
//             modular operations and from constants for the directed cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mod_vec_add_sub;

    localparam int Q     = 3329;
    localparam int W     = 12;
    localparam int LANES = 4;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [LANES-1:0]   err;
        logic [LANES*W-1:0] res;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    mod_vec_add_sub_if #(.W(W), .LANES(LANES), .TAG_W(TAG_W)) bus ();

    mod_vec_add_sub #(
        .Q     (Q),
        .W     (W),
        .LANES (LANES),
        .TAG_W (TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [LANES*W-1:0] a,
                                   input logic [LANES*W-1:0] b,
                                   input logic [2*LANES-1:0] m,
                                   input logic [TAG_W-1:0]   t);
        exp_t e;
        int   x;
        int   y;
        int   r;
        e.res = '0;
        e.err = '0;
        e.tag = t;
        for (int k = 0; k < LANES; k++) begin
            x = int'(a[k*W +: W]);
            y = int'(b[k*W +: W]);
            if ((x >= Q) || (y >= Q)) begin
                e.err[k] = 1'b1;
                r = 0;
            end else begin
                case (m[2*k +: 2])
                    2'b00:   r = (x + y) % Q;
                    2'b01:   r = (x - y + Q) % Q;
                    2'b10:   r = (Q - y) % Q;
                    default: r = (((x + y) % Q) * ((Q + 1) / 2)) % Q;
                endcase
            end
            e.res[k*W +: W] = r[W-1:0];
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_coeff(input bit allow_bad);
        if (allow_bad && ($urandom_range(0, 15) == 0)) begin
            return W'($urandom_range(Q, (1 << W) - 1));
        end
        return W'($urandom_range(0, Q - 1));
    endfunction

    task automatic rand_beat(input bit allow_bad,
                             output logic [LANES*W-1:0] a,
                             output logic [LANES*W-1:0] b,
                             output logic [2*LANES-1:0] m,
                             output logic [TAG_W-1:0]   t);
        for (int k = 0; k < LANES; k++) begin
            a[k*W +: W] = rand_coeff(allow_bad);
            b[k*W +: W] = rand_coeff(allow_bad);
            m[2*k +: 2] = 2'($urandom_range(0, 3));
        end
        t = TAG_W'($urandom);
    endtask

    // Sends one beat into an empty pipeline with out_ready_i=1 and reports
    // what comes back and after how many cycles.
    task automatic run_single(input  logic [LANES*W-1:0] a,
                              input  logic [LANES*W-1:0] b,
                              input  logic [2*LANES-1:0] m,
                              input  logic [TAG_W-1:0]   t,
                              output logic               hs_rdy,
                              output int                 lat,
                              output logic [LANES*W-1:0] res,
                              output logic [LANES-1:0]   err,
                              output logic [TAG_W-1:0]   tg);
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.op1_i       = a;
        bus.op2_i       = b;
        bus.mode_i      = m;
        bus.tag_i       = t;
        @(negedge clk);
        hs_rdy = bus.in_ready_o;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        lat = -1;
        res = '0;
        err = '0;
        tg  = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (lat < 0 && bus.out_valid_o) begin
                lat = c;
                res = bus.result_o;
                err = bus.range_err_o;
                tg  = bus.tag_o;
            end
            if (lat >= 0) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.out_valid_o, bus.result_o, bus.tag_o, bus.range_err_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b r=%h t=%h e=%b expected all zero",
                     bus.out_valid_o, bus.result_o, bus.tag_o, bus.range_err_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready_o);
        end
    endtask

    task automatic test_lane_ops();
        logic [LANES*W-1:0] a, b, res;
        logic [2*LANES-1:0] m;
        logic [LANES-1:0]   err;
        logic [TAG_W-1:0]   tg;
        logic               rdy;
        int                 lat;
        int                 want[LANES];
        a[0*W +: W] = 12'd3328; b[0*W +: W] = 12'd3328; m[1:0] = 2'b00;
        a[1*W +: W] = 12'd5;    b[1*W +: W] = 12'd10;   m[3:2] = 2'b01;
        a[2*W +: W] = 12'd1234; b[2*W +: W] = 12'd0;    m[5:4] = 2'b10;
        a[3*W +: W] = 12'd3;    b[3*W +: W] = 12'd0;    m[7:6] = 2'b11;
        want = '{3327, 3324, 0, 1666};
        run_single(a, b, m, 4'hA, rdy, lat, res, err, tg);
        total++;
        if (rdy !== 1'b1) begin
            bad++; $display("FAIL ops_in_ready: got %b expected 1", rdy);
        end
        total++;
        if (lat != 2) begin
            bad++; $display("FAIL ops_latency: got %0d expected 2", lat);
        end
        for (int k = 0; k < LANES; k++) begin
            total++;
            if (int'(res[k*W +: W]) != want[k]) begin
                bad++;
                $display("FAIL ops_lane%0d: got %0d expected %0d", k, res[k*W +: W], want[k]);
            end
        end
        total++;
        if ({tg, err} !== {4'hA, 4'b0000}) begin
            bad++; $display("FAIL ops_tag_err: got tag=%h err=%b expected tag=a err=0000", tg, err);
        end
    endtask

    task automatic test_boundaries();
        logic [LANES*W-1:0] a, b, res;
        logic [2*LANES-1:0] m;
        logic [LANES-1:0]   err;
        logic [TAG_W-1:0]   tg;
        logic               rdy;
        int                 lat;
        int                 want[LANES];
        a[0*W +: W] = 12'd7;    b[0*W +: W] = 12'd0;    m[1:0] = 2'b01;
        a[1*W +: W] = 12'd0;    b[1*W +: W] = 12'd0;    m[3:2] = 2'b00;
        a[2*W +: W] = 12'd3328; b[2*W +: W] = 12'd3328; m[5:4] = 2'b11;
        a[3*W +: W] = 12'd55;   b[3*W +: W] = 12'd1;    m[7:6] = 2'b10;
        want = '{7, 0, 3328, 3328};
        run_single(a, b, m, 4'h3, rdy, lat, res, err, tg);
        total++;
        if (lat != 2) begin
            bad++; $display("FAIL bnd_latency: got %0d expected 2", lat);
        end
        for (int k = 0; k < LANES; k++) begin
            total++;
            if (int'(res[k*W +: W]) != want[k]) begin
                bad++;
                $display("FAIL bnd_lane%0d: got %0d expected %0d", k, res[k*W +: W], want[k]);
            end
        end
        total++;
        if ({tg, err} !== {4'h3, 4'b0000}) begin
            bad++; $display("FAIL bnd_tag_err: got tag=%h err=%b expected tag=3 err=0000", tg, err);
        end
    endtask

    task automatic test_range_err();
        logic [LANES*W-1:0] a, b, res;
        logic [2*LANES-1:0] m;
        logic [LANES-1:0]   err;
        logic [TAG_W-1:0]   t, tg;
        logic               rdy;
        int                 lat;
        exp_t               e;
        rand_beat(1'b0, a, b, m, t);
        a[2*W +: W] = 12'd3329;
        e = model(a, b, m, t);
        run_single(a, b, m, t, rdy, lat, res, err, tg);
        total++;
        if (err !== 4'b0100) begin
            bad++; $display("FAIL rerr_flags: got %b expected 0100", err);
        end
        total++;
        if (res[2*W +: W] !== 12'd0) begin
            bad++; $display("FAIL rerr_lane2_zero: got %0d expected 0", res[2*W +: W]);
        end
        total++;
        if ({tg, res} !== {e.tag, e.res}) begin
            bad++; $display("FAIL rerr_result: got %h/%h expected %h/%h", tg, res, e.tag, e.res);
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*W-1:0] ca, cb, p_res;
        logic [2*LANES-1:0] cm;
        logic [TAG_W-1:0]   ct, p_tag;
        logic [LANES-1:0]   p_err;
        logic [3:0]         pat;
        logic               have, p_stall, exp_rdy;
        int                 sent, got, cyc;
        exp_t               e;
        pat = 4'b1001;  // cycle 0..3 -> out_ready 1,0,0,1
        have = 1'b0; p_stall = 1'b0; sent = 0; got = 0; cyc = 0;
        p_res = '0; p_tag = '0; p_err = '0;
        exp_q.delete();
        while (got < 20 && cyc < 400) begin
            @(posedge clk); #1;
            bus.out_ready_i = pat[cyc[1:0]];
            if (!have && sent < 20) begin
                rand_beat(1'b1, ca, cb, cm, ct);
                have = 1'b1;
            end
            bus.in_valid_i = have;
            bus.op1_i = ca; bus.op2_i = cb; bus.mode_i = cm; bus.tag_i = ct;
            @(negedge clk);
            if (p_stall) begin
                total++;
                if ({bus.out_valid_o, bus.result_o, bus.tag_o, bus.range_err_o} !==
                    {1'b1, p_res, p_tag, p_err}) begin
                    bad++;
                    $display("FAIL b2b_stall_stable: got v=%b %h/%h/%b expected v=1 %h/%h/%b",
                             bus.out_valid_o, bus.result_o, bus.tag_o, bus.range_err_o,
                             p_res, p_tag, p_err);
                end
            end
            exp_rdy = !((exp_q.size() == 2) && !bus.out_ready_i);
            total++;
            if (bus.in_ready_o !== exp_rdy) begin
                bad++;
                $display("FAIL b2b_in_ready: got %b expected %b (inflight=%0d)",
                         bus.in_ready_o, exp_rdy, exp_q.size());
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra_beat: got tag=%h expected none", bus.tag_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.tag_o, bus.range_err_o, bus.result_o} !== e) begin
                        bad++;
                        $display("FAIL b2b_beat%0d: got %h/%b/%h expected %h/%b/%h", got,
                                 bus.tag_o, bus.range_err_o, bus.result_o, e.tag, e.err, e.res);
                    end
                end
                got++;
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_q.push_back(model(ca, cb, cm, ct));
                sent++;
                have = 1'b0;
            end
            p_stall = bus.out_valid_o && !bus.out_ready_i;
            p_res = bus.result_o; p_tag = bus.tag_o; p_err = bus.range_err_o;
            cyc++;
        end
        bus.in_valid_i = 1'b0;
        total++;
        if (got != 20 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count: got %0d beats (%0d pending) expected 20 (0 pending)",
                     got, exp_q.size());
        end
    endtask

    task automatic test_throughput();
        logic [LANES*W-1:0] ca, cb;
        logic [2*LANES-1:0] cm;
        logic [TAG_W-1:0]   ct;
        int                 sent, got, first_acc, first_out, last_out;
        exp_t               e;
        sent = 0; got = 0; first_acc = -1; first_out = -1; last_out = -1;
        exp_q.delete();
        for (int cyc = 0; cyc < 160 && got < 100; cyc++) begin
            @(posedge clk); #1;
            bus.out_ready_i = 1'b1;
            if (sent < 100) begin
                rand_beat(1'b0, ca, cb, cm, ct);
                bus.in_valid_i = 1'b1;
                bus.op1_i = ca; bus.op2_i = cb; bus.mode_i = cm; bus.tag_i = ct;
            end else begin
                bus.in_valid_i = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid_i) begin
                total++;
                if (bus.in_ready_o !== 1'b1) begin
                    bad++; $display("FAIL thr_in_ready: got %b expected 1 at cycle %0d", bus.in_ready_o, cyc);
                end
            end
            if (bus.out_valid_o) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL thr_extra_beat: got tag=%h expected none", bus.tag_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.tag_o, bus.range_err_o, bus.result_o} !== e) begin
                        bad++;
                        $display("FAIL thr_beat%0d: got %h/%h expected %h/%h",
                                 got, bus.tag_o, bus.result_o, e.tag, e.res);
                    end
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_q.push_back(model(ca, cb, cm, ct));
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
        end
        bus.in_valid_i = 1'b0;
        total++;
        if (got != 100 || (first_out - first_acc) != 2 || (last_out - first_out) != 99) begin
            bad++;
            $display("FAIL thr_timing: got beats=%0d fill=%0d span=%0d expected 100/2/99",
                     got, first_out - first_acc, last_out - first_out);
        end
    endtask

    task automatic test_reset_midstream();
        logic [LANES*W-1:0] ca, cb;
        logic [2*LANES-1:0] cm;
        logic [TAG_W-1:0]   ct;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rand_beat(1'b0, ca, cb, cm, ct);
            bus.in_valid_i = 1'b1;
            bus.op1_i = ca; bus.op2_i = cb; bus.mode_i = cm; bus.tag_i = ct;
        end
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.out_valid_o, bus.in_ready_o} !== 2'b10) begin
            bad++;
            $display("FAIL rst_full: got valid=%b ready=%b expected valid=1 ready=0",
                     bus.out_valid_o, bus.in_ready_o);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({bus.out_valid_o, bus.result_o, bus.tag_o, bus.range_err_o} !== '0) begin
            bad++;
            $display("FAIL rst_async: got v=%b r=%h t=%h e=%b expected all zero",
                     bus.out_valid_o, bus.result_o, bus.tag_o, bus.range_err_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready_o !== 1'b1) begin
            bad++; $display("FAIL rst_release_ready: got %b expected 1", bus.in_ready_o);
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (bus.out_valid_o !== 1'b0) begin
                bad++; $display("FAIL rst_stale_beat: got valid=%b expected 0 at cycle %0d", bus.out_valid_o, c);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.op1_i       = '0;
        bus.op2_i       = '0;
        bus.mode_i      = '0;
        bus.tag_i       = '0;
        test_reset();
        test_lane_ops();
        test_boundaries();
        test_range_err();
        test_back_to_back();
        test_throughput();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mod_vec_add_sub.md
Name: mod_vec_add_sub

Overview:
Parametrised, multi-lane modular adder/subtractor for polynomial coefficient arithmetic (default ML-KEM, Q = 3329). It processes LANES coefficient pairs per beat. Each lane selects its own operation: add, subtract, negate or halve-sum. The datapath is a 2-stage elastic pipeline with valid/ready handshakes on both sides. It sits between coefficient memories and the NTT/basemul units and accepts back-pressure from downstream consumers.

Parameters:
Q, 3329, odd modulus; 2 < Q < 2**W
W, 12, coefficient width in bits
LANES, 4, parallel lanes per beat (1..16)
TAG_W, 4, width of the sideband tag carried alongside data (>= 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid_i  in  1  input beat valid
in_ready_o  out  1  block can accept a beat this cycle
op1_i  in  LANES*W  operand A, lane k at [k*W +: W]
op2_i  in  LANES*W  operand B, same packing
mode_i  in  LANES*2  per-lane op: 00 ADD, 01 SUB, 10 NEG, 11 HALF
tag_i  in  TAG_W  sideband, returned unmodified with the result
out_valid_o  out  1  result beat valid
out_ready_i  in  1  downstream accepts the result
result_o  out  LANES*W  per-lane results, same packing
tag_o  out  TAG_W  tag of the current result beat
range_err_o  out  LANES  per-lane flag: op1 >= Q or op2 >= Q on that beat

Behaviour:
- Reset (rst low, async): out_valid_o=0, result_o=0, tag_o=0, range_err_o=0, all internal valids 0. in_ready_o=1 in the first cycle after release. Reset mid-stream discards all in-flight beats without emitting them.
- Handshake: a beat transfers on in_valid_i & in_ready_o, or on out_valid_o & out_ready_i.
  - out_valid_o, result_o, tag_o and range_err_o stay stable while out_valid_o=1 and out_ready_i=0.
  - in_valid_i is never used to form in_ready_o.
- Pipeline and ready chain:
  - adv2 = !s2_valid | out_ready_i
  - adv1 = !s1_valid | adv2
  - in_ready_o = adv1
  - Result: full throughput (one beat per cycle) with no bubbles while out_ready_i=1.
- Latency: exactly 2 cycles from input handshake to out_valid_o when there are no stalls. Beats leave in acceptance order. No beat is lost or duplicated under any out_ready_i pattern.
- Stage 1 (registered on adv1): capture A and the tag. Capture B' = B for ADD/HALF, or Q-B for SUB/NEG. Capture the range flags. For NEG, force A to 0. B' spans 0..Q and is held in W+1 bits.
- Stage 2 (combinational, then registered on adv2):
  - s = A + B', computed in W+1 bits.
  - r = (s >= Q) ? s-Q : s, giving r in [0, Q-1].
  - HALF: result = r>>1 if r is even, else (r+Q)>>1. This is (A+B)*2^-1 mod Q; Q odd is required.
  - Other modes: result = r.
- Range error: if op1 >= Q or op2 >= Q in lane k, range_err_o[k]=1 and result lane k is forced to 0 on that beat. Other lanes are unaffected. The flag is not sticky.
- Boundaries:
  - SUB with B=0 gives B'=Q and the result is A.
  - NEG with B=0 gives 0.
  - Maximum sum 2Q-1 fits in W+1 bits.
  - Simultaneous input and output handshakes in the same cycle are both honoured.
  - Stalled stage-2 data is never overwritten.
- Elaboration assertions: Q odd, Q < 2**W, LANES in 1..16.

Decomposition:
- poly_arith_pkg holds:
  - Q and the coeff_t typedef (default instantiation).
  - mode enum: MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_NEG=2'b10, MODE_HALF=2'b11.
- One sub-module, mod_lane_core: a single lane's stage-1 prep and stage-2 reduce/halve logic. It is instantiated LANES times by generate.
- The top level owns the valid/ready chain, the tag registers and reset.

Test Plan:
- Lane ops, LANES=4, Q=3329:
  - ADD 3328+3328 gives 3327.
  - SUB 5-10 gives 3324.
  - NEG 0 gives 0.
  - HALF 3+0 gives 1666.
  - All four results appear two cycles after the input handshake, tag echoed.
- Boundaries: SUB A=7,B=0 gives 7. ADD 0+0 gives 0. HALF 3328+3328 gives 3327*inv2 = 3328. NEG B=1 gives 3328.
- Back-pressure:
  - Stream 20 beats with in_valid_i held at 1 and out_ready_i toggling as 1,0,0,1 repeating.
  - Required: outputs match a reference model in order, none lost or duplicated, and outputs stay stable while stalled.
  - in_ready_o is 0 only when both stages are full and out_ready_i=0.
- Throughput: with out_ready_i=1 and in_valid_i=1, 100 random beats emerge on 100 consecutive cycles after a 2-cycle fill.
- Range error: lane 2 op1=3329, other lanes valid. Required: range_err_o=4'b0100, lane 2 result 0, other lanes correct.
- Reset: assert rst low with 2 beats in flight. Required: out_valid_o drops to 0 asynchronously, no stale beat appears after release, and in_ready_o=1.
